// File: rtl/exu_mdu_if.sv
// Issue and writeback handshake bundle between dispatch, the multiply/divide unit and writeback.
// Signal names keep the unit-side direction suffix so both ends read the same.
interface exu_mdu_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      func_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [TAGW-1:0] rd_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] res_o;
    logic [TAGW-1:0] rd_o;

    modport master (
        output valid_i, func_i, rs1_i, rs2_i, rd_i, ready_i,
        input  ready_o, valid_o, res_o, rd_o
    );

    modport slave (
        input  valid_i, func_i, rs1_i, rs2_i, rd_i, ready_i,
        output ready_o, valid_o, res_o, rd_o
    );
endinterface

// File: rtl/exu_mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring divide,
// one op in flight, result held on a valid/ready writeback port until taken.
//
// state  | meaning
// IDLE   | ready for a new op
// BUSY   | iterating, cnt_q counts 31 down to 0
// DONE   | result valid, waiting for writeback ready
module exu_mdu #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    exu_mdu_if.slave   io
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic [TAGW-1:0]   rd_q, rd_d;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              accept;
    logic              sgn1_in, sgn2_in;
    logic              neg1_in, neg2_in;
    logic [XLEN-1:0]   mag1_in, mag2_in;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step;
    logic              mul_neg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   fix_res;

    // Accept-time decode: operand signedness, magnitudes and the cases that bypass iteration.
    always_comb begin
        accept  = io.valid_i && (state_q == S_IDLE) && !flush_i;
        sgn1_in = 1'b0;
        sgn2_in = 1'b0;
        case (io.func_i)
            3'd1, 3'd4, 3'd6: begin
                sgn1_in = 1'b1;
                sgn2_in = 1'b1;
            end
            3'd2: sgn1_in = 1'b1;
            default: ;
        endcase
        neg1_in  = sgn1_in && io.rs1_i[XLEN-1];
        neg2_in  = sgn2_in && io.rs2_i[XLEN-1];
        mag1_in  = neg1_in ? (~io.rs1_i + 1'b1) : io.rs1_i;
        mag2_in  = neg2_in ? (~io.rs2_i + 1'b1) : io.rs2_i;
        div_zero = io.func_i[2] && (io.rs2_i == '0);
        div_ovf  = io.func_i[2] && !io.func_i[0]
                   && (io.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (io.rs2_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = io.func_i[1] ? io.rs1_i : '1;
        else
            special_res = io.func_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration step; acc_q holds {hi, lo} for multiply and {rem, quot} for divide.
    always_comb begin
        mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q})
                            : {1'b0, acc_q[2*XLEN-1:XLEN]};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = {1'b0, rem_sh} - {2'b00, opb_q};
        if (!diff[XLEN+1])
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        step = func_q[2] ? div_next : mul_next;
    end

    always_comb begin
        case (func_q)
            3'd1:    mul_neg = s1_q ^ s2_q;
            3'd2:    mul_neg = s1_q;
            default: mul_neg = 1'b0;
        endcase
        prod = mul_neg ? (~step + 1'b1) : step;
        quot = step[XLEN-1:0];
        rem  = step[2*XLEN-1:XLEN];
        case (func_q)
            3'd0:    fix_res = prod[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:    fix_res = prod[2*XLEN-1:XLEN];
            3'd4:    fix_res = (s1_q ^ s2_q) ? (~quot + 1'b1) : quot;
            3'd5:    fix_res = quot;
            3'd6:    fix_res = s1_q ? (~rem + 1'b1) : rem;
            default: fix_res = rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = special ? S_DONE : S_BUSY;
                S_BUSY: if (cnt_q == 5'd0) state_d = S_DONE;
                S_DONE: if (io.ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        io.ready_o = (state_q == S_IDLE);
        io.valid_o = (state_q == S_DONE);
        io.res_o   = res_q;
        io.rd_o    = rd_q;
    end

    always_comb begin
        func_d = func_q;
        rd_d   = rd_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        opb_d  = opb_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        if (accept) begin
            func_d = io.func_i;
            rd_d   = io.rd_i;
            s1_d   = neg1_in;
            s2_d   = neg2_in;
            cnt_d  = 5'd31;
            // Multiplier sits in the low half so its LSB steers the add; dividend shifts out of it.
            if (io.func_i[2]) begin
                opb_d = mag2_in;
                acc_d = {{XLEN{1'b0}}, mag1_in};
            end else begin
                opb_d = mag1_in;
                acc_d = {{XLEN{1'b0}}, mag2_in};
            end
            if (special)
                res_d = special_res;
        end else if (state_q == S_BUSY && !flush_i) begin
            acc_d = step;
            if (cnt_q == 5'd0)
                res_d = fix_res;
            else
                cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            func_q <= '0;
            rd_q   <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            opb_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else begin
            func_q <= func_d;
            rd_q   <= rd_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            opb_q  <= opb_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: tb/tb_exu_mdu.sv
// Directed bench for exu_mdu: expected results are queued at issue and checked when writeback fires.
module tb_exu_mdu;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    exu_mdu_if #(.XLEN(32), .TAGW(5)) bus ();

    exu_mdu #(.XLEN(32), .TAGW(5)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .io     (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference built on wide native arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2, ua, ub, r;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (f)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb2) >>> 32;
            3'd2: r = (sa * ub) >>> 32;
            3'd3: r = (ua * ub) >> 32;
            3'd4: r = (b == 0) ? -64'sd1 : sa / sb2;
            3'd5: r = (b == 0) ? -64'sd1 : ua / ub;
            3'd6: r = (b == 0) ? ua : sa % sb2;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        chk("ready_at_issue", {31'b0, bus.ready_o}, 32'd1);
        bus.valid_i = 1'b1;
        bus.func_i  = f;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.rd_i    = rd;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.func_i  = 3'($urandom);
        bus.rs1_i   = $urandom;
        bus.rs2_i   = $urandom;
        bus.rd_i    = 5'($urandom);
    endtask

    task automatic expect_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.rd  = rd;
        e.lat = lat;
        sb.push_back(e);
        issue(f, a, b, rd);
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat;
        bit   busy_low;
        bit   stable;
        e = sb.pop_front();
        lat = 1;
        busy_low = 1'b1;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            if (bus.ready_o !== 1'b0) busy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_ready_low_busy"}, {31'b0, busy_low}, 32'd1);
        chk({tag, "_ready_low_done"}, {31'b0, bus.ready_o}, 32'd0);
        chk({tag, "_res"}, bus.res_o, e.res);
        chk({tag, "_rd"}, {27'b0, bus.rd_o}, {27'b0, e.rd});
        stable = 1'b1;
        bus.ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.res_o !== e.res || bus.rd_o !== e.rd)
                stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, {31'b0, stable}, 32'd1);
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        chk({tag, "_valid_drop"}, {31'b0, bus.valid_o}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, bus.ready_o}, 32'd1);
    endtask

    task automatic model_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input int hold);
        expect_op(f, a, b, rd, ref_mdu(f, a, b), ref_lat(f, a, b));
        collect(tag, hold);
    endtask

    initial begin
        bit never_valid;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b1;
        flush = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.func_i  = '0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        bus.rd_i    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_res", bus.res_o, 32'd0);
        chk("rst_rd", {27'b0, bus.rd_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        expect_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);         collect("mul", 0);
        expect_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33); collect("mulh", 0);
        expect_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33); collect("mulhu", 0);
        expect_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33); collect("mulhsu", 0);
        expect_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);         collect("div", 0);
        expect_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);         collect("rem", 0);
        expect_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);                      collect("divu", 0);
        expect_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);                       collect("remu", 0);
        expect_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);                  collect("div0", 0);
        expect_op(3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 1);                         collect("remu0", 0);
        expect_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1); collect("div_ovf", 0);
        expect_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);         collect("rem_ovf", 0);

        // Backpressure then a back-to-back op in the cycle ready_o returns.
        expect_op(3'd0, 32'd1234, 32'd5678, 5'd13, 32'd7006652, 33);            collect("bp", 5);
        expect_op(3'd5, 32'hFFFF_FFFF, 32'd16, 5'd14, 32'h0FFF_FFFF, 33);       collect("b2b", 0);

        for (int i = 0; i < 12; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'd0 : (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            model_op($sformatf("rand%0d", i), rf, ra, rb, 5'($urandom), $urandom_range(0, 2));
        end

        // Flush during cycle 10 of a divide.
        issue(3'd4, 32'd1000, 32'd7, 5'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("flush_ready", {31'b0, bus.ready_o}, 32'd1);
        never_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_o !== 1'b0) never_valid = 1'b0;
            @(negedge clk);
        end
        chk("flush_no_result", {31'b0, never_valid}, 32'd1);

        // Reset during cycle 20 of a multiply; res_o/rd_o still hold the previous result beforehand.
        issue(3'd0, 32'd3, 32'd9, 5'd17);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("midrst_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("midrst_res", bus.res_o, 32'd0);
        chk("midrst_rd", {27'b0, bus.rd_o}, 32'd0);

        // valid_i with flush_i: a would-be special op must not be accepted.
        bus.valid_i = 1'b1;
        bus.func_i  = 3'd4;
        bus.rs1_i   = 32'd5;
        bus.rs2_i   = 32'd0;
        bus.rd_i    = 5'd21;
        flush = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        flush = 1'b0;
        chk("vflush_ready", {31'b0, bus.ready_o}, 32'd1);
        never_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.valid_o !== 1'b0) never_valid = 1'b0;
            @(negedge clk);
        end
        chk("vflush_no_accept", {31'b0, never_valid}, 32'd1);

        model_op("after", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd22, 1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_mdu.md
# exu_mdu

Iterative RV32M multiply/divide unit for the execute stage, sitting beside the single-cycle ALU. It is the responder on a valid/ready issue handshake driven by dispatch: it accepts one M-extension uop, runs a fixed 32-step shift-add multiply or restoring divide, and presents the result with its destination tag on a valid/ready writeback handshake. One operation is in flight at a time. A flush kills it.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- TAGW, 5, destination-tag width (architectural rd index).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- flush_i  in  1  kills any in-flight op; has priority over everything except rst_i.
- valid_i  in  1  dispatch offers an op.
- ready_o  out  1  unit can accept; high only in IDLE.
- func_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  XLEN  operand 1 (multiplicand/dividend).
- rs2_i  in  XLEN  operand 2 (multiplier/divisor).
- rd_i  in  TAGW  destination tag.
- valid_o  out  1  result available.
- ready_i  in  1  writeback accepts the result.
- res_o  out  XLEN  result; stable while valid_o is high.
- rd_o  out  TAGW  tag captured at accept.

## Operation
- States: IDLE, BUSY, DONE.
- Accept when valid_i && ready_o && !flush_i. Capture func, rd, operand signs and operand magnitudes.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - A signed negative operand is replaced by its two's-complement magnitude.
- Special cases resolved at accept (IDLE→DONE directly):
  - Divide by zero (rs2==0, func 4–7): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1==0x80000000, rs2==0xFFFFFFFF, func 4 or 6): DIV gives 0x80000000; REM gives 0.
- Otherwise IDLE→BUSY with a 5-bit step counter = 31.
- Multiply step: if multiplier LSB is 1, add multiplicand into the upper half of the 64-bit accumulator. Then shift the {carry, accumulator} pair right by 1.
- Divide step (restoring): shift {rem, quot} left by 1, then trial-subtract the divisor from rem. If there is no borrow, keep the difference and set quot LSB to 1.
- When counter==0, BUSY→DONE. The final fixup is registered into res_o on that edge:
  - Multiply: product negated if the sign flag is set. Sign flag = s1^s2 for MULH, s1 for MULHSU, 0 for MULHU and MUL. MUL returns product[31:0]; the others return product[63:32].
  - Divide: quotient negated if s1^s2 (DIV only); remainder negated if s1 (REM only).
- DONE: valid_o=1. On ready_i, DONE→IDLE.
- flush_i in any state → IDLE on the next edge; valid_o drops; the result is discarded.

## Timing
- Reset values: state IDLE, ready_o=1, valid_o=0, res_o=0, rd_o=0, counter=0.
- Normal op accepted at the edge ending cycle N: BUSY in cycles N+1..N+32; valid_o high from cycle N+33. Latency is 33 regardless of operand values.
- Special-case op accepted in cycle N: valid_o high in cycle N+1.
- ready_o is low from N+1 until the cycle after the output handshake. No accept occurs in the same cycle as an output handshake.
- valid_o, res_o and rd_o are held unchanged while ready_i is low (unbounded backpressure).
- Simultaneous flush_i and valid_i in IDLE: no accept.
- Simultaneous flush_i and ready_i in DONE: treated as flush; the handshake does not count.
- rst_i mid-op behaves like flush and also clears res_o and rd_o.
- Inputs are sampled only at the accept edge. Operand changes afterwards are ignored.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5, accepted cycle 0 -> valid_o at cycle 33, res_o=0xFFFFFFEB, rd_o=5; ready_o low for cycles 1–33.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM same operands -> 0.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o rises -> res_o/rd_o stable and ready_o=0; then ready_i=1 -> valid_o=0 and ready_o=1 on the next cycle; a back-to-back second op is accepted then.
- Flush at cycle 10 of a DIV -> no valid_o, ready_o=1 at cycle 11. Assert rst_i at cycle 20 of a MUL -> all outputs at reset values next cycle. valid_i together with flush_i -> no accept.
